// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter family: FSM encodings, clog2, stats width.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fifo_write_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int STAT_WIDTH = 16;

   // Ceiling log2; clog2(1) is 0, so callers add 1 where a zero-width field would result.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Scan from the farthest offset down so the nearest set bit from rr_ptr wins.
   always_comb begin
      int            j;
      logic [IW-1:0] jj;
      found = |req;
      idx   = '0;
      j     = 0;
      jj    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j  = (int'(rr_ptr) + k) % N;
         jj = IW'(j);
         if (req[jj]) begin
            idx = jj;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ producers.
// Latency: one-cycle arbitration bubble per burst, then one word per cycle (combinational gnt/wr_en/din).
// Backpressure: fifo_full stalls the owner indefinitely without losing ownership. Optional FIFO_ARB_STATS_EN adds per-producer counters.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          busy,
   output logic [clog2(NUM_REQ)-1:0]     owner,
   input  logic [clog2(NUM_REQ)-1:0]     stat_sel,
   input  logic                          stat_clr,
   output logic [STAT_WIDTH-1:0]         stat_count
);

   localparam int IW = clog2(NUM_REQ);
   localparam int BW = clog2(MAX_BURST) + 1;

   arb_state_t      state;
   logic [IW-1:0]   rr_ptr;
   logic [BW-1:0]   beat_cnt;
   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic            in_burst;
   logic            accept;
   logic            burst_end;
   logic [IW-1:0]   next_ptr;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
      assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign in_burst   = (state == ST_BURST);
   assign accept     = in_burst && req[owner] && !fifo_full;
   assign fifo_wr_en = accept;
   assign fifo_din   = words[owner];
   assign next_ptr   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   // A burst closes on its last word, on hitting the burst cap, or when the owner withdraws while the FIFO has room.
   assign burst_end = (accept && (req_last[owner] || (beat_cnt == BW'(MAX_BURST - 1))))
                    || (in_burst && !req[owner] && !fifo_full);

   // Only the owner can be granted, and only when its word can actually go into the FIFO.
   always_comb begin
      gnt        = '0;
      gnt[owner] = accept;
   end

   // Arbitration FSM: IDLE picks the next owner, BURST streams its words until the burst ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  owner    <= pick_idx;
                  beat_cnt <= '0;
                  state    <= ST_BURST;
                  busy     <= 1'b1;
               end
            end
            ST_BURST: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
               if (burst_end) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

   // Saturating per-producer accepted-word counters; a clear overrides a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else if (accept && (stat_q[owner] != '1)) begin
         stat_q[owner] <= stat_q[owner] + 1'b1;
      end
   end

   assign stat_count = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`else
   logic unused_stat;
   assign unused_stat = ^{stat_sel, stat_clr};
   assign stat_count  = '0;
`endif

endmodule
